// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC control slice.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_IN,
    MUL,
    ADD,
    MRST,
    DONE,
    ERR
  } state_t;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_MUL_TIMEOUT = 16;

endpackage

// File: rtl/mac_mul_watchdog.sv
// Counts cycles spent waiting on the multiplier and flags the last permitted one.
module mac_mul_watchdog
  import mac_pkg::*;
#(
  parameter int TIMEOUT = DEF_MUL_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WD_W'(1);
    end
  end

  // A zero timeout disables the watchdog entirely.
  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mac_controller.sv
// Control FSM sequencing clear, operand load, multiply and accumulate for a MAC job.
module mac_controller
  import mac_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MUL_TIMEOUT = DEF_MUL_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             clr_dp,
  output logic             ldA,
  output logic             ldB,
  output logic             rst_for_mul,
  output logic             start_mul,
  input  logic             valid_mul,
  output logic             start_adder,
  output logic             ldacc
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] rem;
  logic             start_accept;
  logic             wdog_expired;

  assign start_accept = start && ((state == IDLE) || (state == ERR));

  mac_mul_watchdog #(
    .TIMEOUT (MUL_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != MUL),
    .enable  (state == MUL),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= '0;
    end else if (start_accept && (num_terms != '0)) begin
      rem <= num_terms;
    end else if (state == ADD) begin
      rem <= rem - CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, ERR: begin
        if (start) begin
          next_state = (num_terms != '0) ? CLEAR : DONE;
        end
      end
      CLEAR:   next_state = WAIT_IN;
      WAIT_IN: begin
        if (in_valid) begin
          next_state = MUL;
        end
      end
      // A result arriving on the expiry cycle still counts as an answer.
      MUL: begin
        if (valid_mul) begin
          next_state = ADD;
        end else if (wdog_expired) begin
          next_state = ERR;
        end
      end
      ADD:     next_state = (rem == CNT_W'(1)) ? DONE : MRST;
      MRST:    next_state = WAIT_IN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    in_ready    = 1'b0;
    clr_dp      = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    rst_for_mul = 1'b0;
    start_mul   = 1'b0;
    start_adder = 1'b0;
    ldacc       = 1'b0;
    unique case (state)
      CLEAR: begin
        busy        = 1'b1;
        clr_dp      = 1'b1;
        rst_for_mul = 1'b1;
      end
      WAIT_IN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        ldA      = in_valid;
        ldB      = in_valid;
      end
      MUL: begin
        busy      = 1'b1;
        start_mul = 1'b1;
      end
      ADD: begin
        busy        = 1'b1;
        start_adder = 1'b1;
        ldacc       = 1'b1;
      end
      MRST: begin
        busy        = 1'b1;
        rst_for_mul = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

endmodule
